// File: rtl/updown_counter_ctrl_if.sv
// Control and status bundle of the bounded up/down counter controller.
// The master side drives start/stop/hold and the configuration; the slave side reports count and status.
interface updown_counter_ctrl_if #(
    parameter int WIDTH = 3,
    parameter int DIV_W = 4,
    parameter int SWP_W = 4
);
    logic             start;
    logic             stop;
    logic             hold;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [DIV_W-1:0] div;
    logic [SWP_W-1:0] sweeps;
    logic [WIDTH-1:0] count_out;
    logic             dir_out;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output start, stop, hold, mode, lo, hi, div, sweeps,
        input  count_out, dir_out, busy, done, cfg_err
    );

    modport slave (
        input  start, stop, hold, mode, lo, hi, div, sweeps,
        output count_out, dir_out, busy, done, cfg_err
    );
endinterface

// File: rtl/updown_counter_ctrl.sv
// Programmable bounded up/down counter sequencer: latches bounds, mode, rate and sweep count on start,
// then steps the count at the programmed rate until the sweeps complete or stop aborts the run.
module updown_counter_ctrl #(
    parameter int WIDTH = 3,
    parameter int DIV_W = 4,
    parameter int SWP_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    updown_counter_ctrl_if.slave bus
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic             dir_q,     dir_d;
    logic [DIV_W-1:0] presc_q,   presc_d;
    logic [SWP_W-1:0] swp_q,     swp_d;
    logic             cfg_err_q, cfg_err_d;

    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic [SWP_W-1:0] sweeps_q;
    logic             cfg_load;

    logic [WIDTH-1:0] step_count;
    logic             step_dir;
    logic             sweep_end;
    logic [SWP_W-1:0] swp_next;
    logic             last_sweep;
    logic             cfg_bad;

    // Result of one step from the current count under the latched mode.
    always_comb begin
        step_count = count_q;
        step_dir   = dir_q;
        sweep_end  = 1'b0;
        case (mode_q)
            MODE_UP: begin
                if (count_q == hi_q) begin
                    step_count = lo_q;
                    sweep_end  = 1'b1;
                end else begin
                    step_count = count_q + 1'b1;
                end
            end
            MODE_DOWN: begin
                if (count_q == lo_q) begin
                    step_count = hi_q;
                    sweep_end  = 1'b1;
                end else begin
                    step_count = count_q - 1'b1;
                end
            end
            default: begin
                // Ping-pong: direction flips on the same edge that reaches a bound.
                if (!dir_q) begin
                    step_count = count_q + 1'b1;
                    if (step_count == hi_q) begin
                        step_dir = 1'b1;
                    end
                end else begin
                    step_count = count_q - 1'b1;
                    if (step_count == lo_q) begin
                        step_dir  = 1'b0;
                        sweep_end = 1'b1;
                    end
                end
            end
        endcase
    end

    assign swp_next   = swp_q + 1'b1;
    assign last_sweep = sweep_end && (sweeps_q != '0) && (swp_next == sweeps_q);
    assign cfg_bad    = (bus.lo >= bus.hi) || (bus.mode == MODE_RSVD);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dir_d     = dir_q;
        presc_d   = presc_q;
        swp_d     = swp_q;
        cfg_err_d = 1'b0;
        cfg_load  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.stop) begin
                    presc_d = '0;
                    swp_d   = '0;
                end else if (bus.start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_load = 1'b1;
                        presc_d  = '0;
                        swp_d    = '0;
                        count_d  = (bus.mode == MODE_DOWN) ? bus.hi : bus.lo;
                        dir_d    = (bus.mode == MODE_DOWN);
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    presc_d = '0;
                    swp_d   = '0;
                    state_d = S_IDLE;
                end else if (bus.hold) begin
                    state_d = S_PAUSE;
                end else if (presc_q == div_q) begin
                    presc_d = '0;
                    count_d = step_count;
                    dir_d   = step_dir;
                    if (sweep_end) begin
                        swp_d = swp_next;
                    end
                    if (last_sweep) begin
                        state_d = S_DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (bus.stop) begin
                    presc_d = '0;
                    swp_d   = '0;
                    state_d = S_IDLE;
                end else if (!bus.hold) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                presc_d = '0;
                swp_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            dir_q     <= 1'b0;
            presc_q   <= '0;
            swp_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            presc_q   <= presc_d;
            swp_q     <= swp_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Configuration is only meaningful once a run has been accepted, so it carries no reset.
    always_ff @(posedge clk) begin
        if (cfg_load) begin
            lo_q     <= bus.lo;
            hi_q     <= bus.hi;
            mode_q   <= bus.mode;
            div_q    <= bus.div;
            sweeps_q <= bus.sweeps;
        end
    end

    assign bus.count_out = count_q;
    assign bus.dir_out   = dir_q;
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed bench for updown_counter_ctrl: ping-pong, up/down wrap, config rejection, hold/stop and reset.
module tb_updown_counter_ctrl;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    updown_counter_ctrl_if #(.WIDTH(3), .DIV_W(4), .SWP_W(4)) bus ();

    updown_counter_ctrl #(.WIDTH(3), .DIV_W(4), .SWP_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [2:0] l, input logic [2:0] h,
                           input logic [3:0] d, input logic [3:0] s);
        bus.mode   = m;
        bus.lo     = l;
        bus.hi     = h;
        bus.div    = d;
        bus.sweeps = s;
    endtask

    int exp1[14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    int exp2[8]  = '{3, 4, 5, 2, 3, 4, 5, 2};
    int exp3[10] = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2};

    initial begin
        int prev;
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.hold   = 1'b0;
        set_cfg(2'b00, 3'd0, 3'd0, 4'd0, 4'd0);
        tick();
        tick();
        check("rst_count", bus.count_out, 0);
        check("rst_dir", bus.dir_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_cfg_err", bus.cfg_err, 0);
        reset_n = 1'b1;
        tick();

        // 1: ping-pong 0..7..0, one sweep
        set_cfg(2'b10, 3'd0, 3'd7, 4'd0, 4'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        set_cfg(2'b00, 3'd3, 3'd4, 4'd9, 4'd9);
        check("t1_start_busy", bus.busy, 1);
        check("t1_start_count", bus.count_out, 0);
        check("t1_start_dir", bus.dir_out, 0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("t1_count", bus.count_out, exp1[i-1]);
            check("t1_dir", bus.dir_out, (i >= 7 && i < 14));
            check("t1_done", bus.done, (i == 14));
            check("t1_busy", bus.busy, (i < 14));
        end
        tick();
        check("t1_idle_done", bus.done, 0);
        check("t1_idle_busy", bus.busy, 0);
        check("t1_idle_count", bus.count_out, 0);

        // 2: up-wrap 2..5, div 2, two sweeps
        set_cfg(2'b00, 3'd2, 3'd5, 4'd2, 4'd2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t2_start_count", bus.count_out, 2);
        prev = 2;
        for (int s = 0; s < 8; s++) begin
            tick();
            tick();
            check("t2_between", bus.count_out, prev);
            tick();
            check("t2_count", bus.count_out, exp2[s]);
            check("t2_done", bus.done, (s == 7));
            check("t2_busy", bus.busy, (s != 7));
            prev = exp2[s];
        end
        tick();
        check("t2_after_busy", bus.busy, 0);
        check("t2_after_done", bus.done, 0);
        check("t2_after_count", bus.count_out, 2);

        // 3: down-wrap 1..4, endless, stop at count 2
        set_cfg(2'b01, 3'd1, 3'd4, 4'd0, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t3_start_count", bus.count_out, 4);
        check("t3_start_dir", bus.dir_out, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_count", bus.count_out, exp3[i]);
            check("t3_done", bus.done, 0);
            check("t3_dir", bus.dir_out, 1);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("t3_stop_busy", bus.busy, 0);
        check("t3_stop_count", bus.count_out, 2);
        check("t3_stop_done", bus.done, 0);
        tick();
        check("t3_post_done", bus.done, 0);
        check("t3_post_count", bus.count_out, 2);

        // 4: rejected configurations
        set_cfg(2'b00, 3'd5, 3'd5, 4'd0, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t4a_cfg_err", bus.cfg_err, 1);
        check("t4a_busy", bus.busy, 0);
        check("t4a_count", bus.count_out, 2);
        tick();
        check("t4a_cfg_err_clr", bus.cfg_err, 0);
        set_cfg(2'b11, 3'd1, 3'd4, 4'd0, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t4b_cfg_err", bus.cfg_err, 1);
        check("t4b_busy", bus.busy, 0);
        check("t4b_count", bus.count_out, 2);
        tick();
        check("t4b_cfg_err_clr", bus.cfg_err, 0);
        check("t4b_busy_clr", bus.busy, 0);

        // 5: ping-pong div 3 with hold mid-prescale, then hold+stop
        set_cfg(2'b10, 3'd0, 3'd7, 4'd3, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("t5_pre_step", bus.count_out, 0);
        tick();
        check("t5_first_step", bus.count_out, 1);
        tick();
        tick();
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_hold_count", bus.count_out, 1);
            check("t5_hold_busy", bus.busy, 1);
        end
        bus.hold = 1'b0;
        tick();
        check("t5_resume0", bus.count_out, 1);
        tick();
        check("t5_resume1", bus.count_out, 1);
        tick();
        check("t5_resume_step", bus.count_out, 2);
        check("t5_resume_dir", bus.dir_out, 0);
        bus.hold = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.hold = 1'b0;
        bus.stop = 1'b0;
        check("t5_abort_busy", bus.busy, 0);
        check("t5_abort_count", bus.count_out, 2);
        check("t5_abort_done", bus.done, 0);

        // 6: reset mid-run at count 6 descending
        set_cfg(2'b10, 3'd0, 3'd7, 4'd0, 4'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        check("t6_pre_count", bus.count_out, 6);
        check("t6_pre_dir", bus.dir_out, 1);
        reset_n   = 1'b0;
        bus.start = 1'b1;
        tick();
        check("t6_rst_count", bus.count_out, 0);
        check("t6_rst_dir", bus.dir_out, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_done", bus.done, 0);
        check("t6_rst_cfg_err", bus.cfg_err, 0);
        reset_n   = 1'b1;
        bus.start = 1'b0;
        tick();
        check("t6_after_busy", bus.busy, 0);
        check("t6_after_count", bus.count_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
